fifo_rd_stream: RTL and testbench

Read-side drain stage placed directly downstream of the team's synchronous FIFO. It pulls words through the FIFO's `rd_en`/`data_out`/`empty` port set and re-presents them as a registered valid/ready stream with packet framing. Its credit-based read issue hides the FIFO's one-cycle read latency, never underflows the FIFO, and sustains one word per cycle under continuous `m_ready`.

---
 rtl/fifo_pkg.sv | 10 +
 rtl/fifo_rd_stream_if.sv | 38 +++
 rtl/stream_skid2.sv | 53 +++++
 rtl/fifo_rd_stream.sv | 82 ++++++++
 tb/tb_fifo_rd_stream.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO word definitions for the FIFO and its
// read-side stream stage.
package fifo_pkg;

  localparam int FIFO_WIDTH = 16;
  localparam int FIFO_DEPTH = 8;

  typedef logic [FIFO_WIDTH-1:0] fifo_word_t;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus valid/ready output stream.
// The master modport is the drain stage's view.
interface fifo_rd_stream_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_WIDTH
);

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic                  fifo_rd_en;

  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_last;
  logic                  m_ready;

  modport master (
    input  fifo_empty,
    input  fifo_data_out,
    input  m_ready,
    output fifo_rd_en,
    output m_data,
    output m_valid,
    output m_last
  );

  modport slave (
    output fifo_empty,
    output fifo_data_out,
    output m_ready,
    input  fifo_rd_en,
    input  m_data,
    input  m_valid,
    input  m_last
  );

endinterface

// File: rtl/stream_skid2.sv
// Two-entry in-order output buffer.
// head is always entry 0; occ counts valid entries.
module stream_skid2 #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] h0;
  logic [DATA_WIDTH-1:0] h1;
  logic [1:0]            cnt;

  // Upstream credit keeps push from landing in a full buffer,
  // and pop is only raised while cnt is nonzero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h0  <= '0;
      h1  <= '0;
      cnt <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) h0 <= push_data;
          else             h1 <= push_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          if (cnt == 2'd2) h0 <= h1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            h0 <= push_data;
          end else begin
            h0 <= h1;
            h1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = h0;
  assign occ  = cnt;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO drain stage: credit-based reads, framed output stream.
// Optional counters: define FIFO_RD_STREAM_STATS_EN.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_WIDTH,
  parameter int PKT_LEN    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              drain_en,
  fifo_rd_stream_if.master  bus
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [31:0]       stat_words,
  output logic [31:0]       stat_stalls
`endif
);

  localparam int WCW =
    (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [WCW-1:0] WLAST =
    WCW'(PKT_LEN - 1);

  logic           inflight;
  logic           pop;
  logic [1:0]     occ;
  logic [1:0]     credit;
  logic [WCW-1:0] wcnt;

  assign pop = bus.m_valid & bus.m_ready;

  // Buffered plus in-flight words after this cycle's pop.
  assign credit = occ + {1'b0, inflight} - {1'b0, pop};

  assign bus.fifo_rd_en = !rst
                        && drain_en
                        && !bus.fifo_empty
                        && (credit < 2'd2);

  stream_skid2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (bus.fifo_data_out),
    .pop       (pop),
    .head      (bus.m_data),
    .occ       (occ)
  );

  assign bus.m_valid = (occ != 2'd0);
  assign bus.m_last  = bus.m_valid && (wcnt == WLAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
      wcnt     <= '0;
    end else begin
      inflight <= bus.fifo_rd_en;
      if (pop) begin
        if (wcnt == WLAST) wcnt <= '0;
        else               wcnt <= wcnt + 1'b1;
      end
    end
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_words  <= '0;
      stat_stalls <= '0;
    end else begin
      if (pop) stat_words <= stat_words + 32'd1;
      if (bus.m_valid && !bus.m_ready)
        stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: FIFO model, word-order scoreboard,
// cycle table, directed corner cases and random traffic.
module tb_fifo_rd_stream;
  import fifo_pkg::*;

  localparam int DW = 16;
  localparam int PL = 4;
  localparam int MEMSZ = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic drain_en = 1'b0;

  always #5 clk = ~clk;

  fifo_rd_stream_if #(.DATA_WIDTH(DW)) bus();

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0] stat_words;
  logic [31:0] stat_stalls;
`endif

  fifo_rd_stream #(
    .DATA_WIDTH (DW),
    .PKT_LEN    (PL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .drain_en    (drain_en),
    .bus         (bus)
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    .stat_words  (stat_words),
    .stat_stalls (stat_stalls)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Behavioural synchronous FIFO: registered data_out.
  logic [DW-1:0] mem [0:MEMSZ-1];
  int   wptr = 0;
  int   rptr = 0;
  logic underflow = 1'b0;

  assign bus.fifo_empty = (rptr == wptr);

  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      if (rptr == wptr) begin
        underflow <= 1'b1;
      end else begin
        bus.fifo_data_out <= mem[rptr % MEMSZ];
        rptr <= rptr + 1;
      end
    end
  end

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: words leave in FIFO order; framing by count.
  logic [DW-1:0] exp_q [$];
  int   rd_total = 0;
  int   delivered = 0;
  int   pkt_idx = 0;
  bit   hold_pend = 0;
  logic [DW-1:0] hold_data;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.fifo_empty)
        chk("rd_while_empty", 32'(bus.fifo_rd_en), 0);
      if (hold_pend) begin
        chk("hold_valid", 32'(bus.m_valid), 1);
        chk("hold_data", 32'(bus.m_data), 32'(hold_data));
      end
      if (bus.fifo_rd_en) rd_total++;
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got %0h want none",
                   bus.m_data);
        end else begin
          chk("data", 32'(bus.m_data), 32'(exp_q.pop_front()));
        end
        chk("last", 32'(bus.m_last), 32'(pkt_idx == PL - 1));
        pkt_idx = (pkt_idx + 1) % PL;
        delivered++;
      end
      hold_pend = bus.m_valid && !bus.m_ready;
      hold_data = bus.m_data;
    end
  end

  task automatic load(logic [DW-1:0] w);
    mem[wptr % MEMSZ] = w;
    wptr++;
    exp_q.push_back(w);
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Buffered and in-flight words are lost on reset.
  task automatic do_reset();
    int n;
    @(posedge clk);
    #1 rst = 1'b1;
    n = rd_total - delivered;
    repeat (n) begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    delivered = rd_total;
    pkt_idx = 0;
    hold_pend = 0;
    #1;
    chk("rst_valid", 32'(bus.m_valid), 0);
    chk("rst_last", 32'(bus.m_last), 0);
    chk("rst_data", 32'(bus.m_data), 0);
    chk("rst_rd_en", 32'(bus.fifo_rd_en), 0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_drain(int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !bus.m_valid) break;
    end
    chk("drain_left", 32'(exp_q.size()), 0);
  endtask

  typedef struct {
    logic          drain;
    logic          ready;
    logic          exp_rd;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic          exp_last;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int d0;
    bit seen;

    // Eight back-to-back words: reads cycles 0..7, word k in k+1.
    for (int c = 0; c < 11; c++) begin
      tbl[c].drain     = 1'b1;
      tbl[c].ready     = 1'b1;
      tbl[c].exp_rd    = (c <= 7);
      tbl[c].exp_valid = (c >= 2 && c <= 9);
      tbl[c].exp_data  = DW'(c - 1);
      tbl[c].exp_last  = (c == 5 || c == 9);
    end

    bus.m_ready = 1'b0;
    do_reset();

    drain_en = 1'b1;
    bus.m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) load(DW'(i));
    for (int c = 0; c < 11; c++) begin
      drain_en = tbl[c].drain;
      bus.m_ready = tbl[c].ready;
      @(negedge clk);
      chk("tbl_rd", 32'(bus.fifo_rd_en), 32'(tbl[c].exp_rd));
      chk("tbl_valid", 32'(bus.m_valid),
          32'(tbl[c].exp_valid));
      chk("tbl_last", 32'(bus.m_last), 32'(tbl[c].exp_last));
      if (tbl[c].exp_valid)
        chk("tbl_data", 32'(bus.m_data),
            32'(tbl[c].exp_data));
      @(posedge clk);
      #1;
    end

    // Backpressure: only two reads, head held.
    do_reset();
    bus.m_ready = 1'b0;
    r0 = rd_total;
    d0 = delivered;
    for (int i = 1; i <= 5; i++) load(DW'(16'h0100 + i));
    step(8);
    chk("bp_reads", 32'(rd_total - r0), 2);
    chk("bp_valid", 32'(bus.m_valid), 1);
    chk("bp_data", 32'(bus.m_data), 32'h0101);
    chk("bp_rd_low", 32'(bus.fifo_rd_en), 0);
    bus.m_ready = 1'b1;
    wait_drain(30);
    chk("bp_count", 32'(delivered - d0), 5);

    // Single word.
    do_reset();
    r0 = rd_total;
    d0 = delivered;
    load(16'hBEEF);
    wait_drain(20);
    step(2);
    chk("one_reads", 32'(rd_total - r0), 1);
    chk("one_underflow", 32'(underflow), 0);
    chk("one_count", 32'(delivered - d0), 1);

    // drain_en dropped after the first read.
    do_reset();
    d0 = delivered;
    for (int i = 1; i <= 3; i++) load(DW'(16'h0300 + i));
    @(negedge clk);
    #1;
    chk("de_first_rd", 32'(bus.fifo_rd_en), 1);
    @(posedge clk);
    #1 drain_en = 1'b0;
    r0 = rd_total;
    step(6);
    chk("de_reads", 32'(rd_total - r0), 0);
    chk("de_inflight", 32'(delivered - d0), 1);
    chk("de_fifo_kept", 32'(bus.fifo_empty), 0);
    drain_en = 1'b1;
    wait_drain(30);
    chk("de_count", 32'(delivered - d0), 3);

    // Reset with two words buffered restarts framing.
    do_reset();
    bus.m_ready = 1'b0;
    for (int i = 1; i <= 6; i++) load(DW'(16'h0500 + i));
    step(5);
    chk("mr_full", 32'(bus.m_valid), 1);
    do_reset();
    d0 = delivered;
    bus.m_ready = 1'b1;
    wait_drain(30);
    chk("mr_count", 32'(delivered - d0), 4);

`ifdef FIFO_RD_STREAM_STATS_EN
    do_reset();
    for (int i = 1; i <= 8; i++) load(DW'(16'h0700 + i));
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = bus.m_valid;
    end
    chk("st_valid_seen", 32'(seen), 1);
    @(posedge clk);
    #1 bus.m_ready = 1'b0;
    step(3);
    bus.m_ready = 1'b1;
    wait_drain(40);
    step(1);
    chk("st_words", stat_words, 8);
    chk("st_stalls", stat_stalls, 3);
`else
    seen = 0;
`endif

    // Random traffic against the scoreboard.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      drain_en = ($urandom_range(0, 9) != 0);
      bus.m_ready = ($urandom_range(0, 3) != 0);
      if ((wptr - rptr) < FIFO_DEPTH &&
          $urandom_range(0, 1) == 1)
        load(DW'($urandom));
      step(1);
    end
    drain_en = 1'b1;
    bus.m_ready = 1'b1;
    wait_drain(100);
    chk("rnd_underflow", 32'(underflow), 0);
    chk("rnd_all_read", 32'(wptr - rptr), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
